// File: rtl/vga_pixel_sink.sv
// vga_pixel_sink
//   Receives pixel writes (x, y, colour, strobe) from the drawing engines,
//   clips them to the visible screen, queues them in a small FIFO and
//   drains them one per cycle into a valid/ready framebuffer write port.
//
// Ports
//   clock, reset            rising-edge clock, synchronous active-high reset
//   vga_x/vga_y/vga_colour  pixel column / row / 6:6:6 colour
//   vga_write               pixel strobe, one pixel per cycle
//   fb_addr/fb_data/fb_we   framebuffer write (fb_we is the valid)
//   fb_ready                framebuffer accepts the write this cycle
//   fifo_count              entries in FIFO storage (output register excluded)
//   overflow                sticky: an in-range pixel was dropped
//   dropped_count           saturating count of dropped in-range pixels
//   busy                    anything buffered or pending
module vga_pixel_sink #(
    parameter int DEPTH_LOG2 = 3,
    parameter int SCREEN_W   = 160,
    parameter int SCREEN_H   = 120
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [7:0]            vga_x,
    input  logic [6:0]            vga_y,
    input  logic [17:0]           vga_colour,
    input  logic                  vga_write,
    output logic [14:0]           fb_addr,
    output logic [17:0]           fb_data,
    output logic                  fb_we,
    input  logic                  fb_ready,
    output logic [DEPTH_LOG2:0]   fifo_count,
    output logic                  overflow,
    output logic [7:0]            dropped_count,
    output logic                  busy
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [7:0]          X_LIM = 8'(SCREEN_W);
    localparam logic [6:0]          Y_LIM = 7'(SCREEN_H);
    localparam logic [DEPTH_LOG2:0] FULL  = {1'b1, {DEPTH_LOG2{1'b0}}};

    typedef struct packed {
        logic [14:0] addr;
        logic [17:0] colour;
    } entry_t;

    typedef enum logic {
        IDLE,
        PRESENT
    } state_t;

    // FIFO storage and bookkeeping
    entry_t                  mem_q [DEPTH];
    logic [DEPTH_LOG2-1:0]   wr_ptr_q, wr_ptr_d;
    logic [DEPTH_LOG2-1:0]   rd_ptr_q, rd_ptr_d;
    logic [DEPTH_LOG2:0]     count_q, count_d;

    // Output register
    state_t                  state_q, state_d;
    entry_t                  out_q, out_d;

    logic                    overflow_q, overflow_d;
    logic [7:0]              dropped_q, dropped_d;

    logic                    in_range;
    logic                    push;
    logic                    pop;
    logic                    drop;
    entry_t                  in_entry;

    // Address is formed at push time so the FIFO holds final word addresses.
    always_comb begin
        in_entry        = '0;
        in_entry.addr   = 15'(vga_y) * 15'(SCREEN_W) + 15'(vga_x);
        in_entry.colour = vga_colour;
    end

    assign in_range = (vga_x < X_LIM) && (vga_y < Y_LIM);

    // A pop frees a slot in the same cycle, so a full FIFO still admits a push
    // when the head is moving into the output register.
    assign pop  = (count_q != '0) && ((state_q == IDLE) || fb_ready);
    assign push = vga_write && in_range && ((count_q != FULL) || pop);
    assign drop = vga_write && in_range && !push;

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        state_d    = state_q;
        out_d      = out_q;
        overflow_d = overflow_q;
        dropped_d  = dropped_q;

        if (push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end

        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase

        case (state_q)
            IDLE: begin
                if (pop) begin
                    out_d   = mem_q[rd_ptr_q];
                    state_d = PRESENT;
                end
            end
            PRESENT: begin
                // Stalled writes hold everything; a completed write either
                // chains straight into the next entry or falls back to IDLE.
                if (fb_ready) begin
                    if (pop) begin
                        out_d = mem_q[rd_ptr_q];
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        if (drop) begin
            overflow_d = 1'b1;
            if (dropped_q != 8'hFF) begin
                dropped_d = dropped_q + 8'd1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            state_q    <= IDLE;
            out_q      <= '0;
            overflow_q <= 1'b0;
            dropped_q  <= '0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            state_q    <= state_d;
            out_q      <= out_d;
            overflow_q <= overflow_d;
            dropped_q  <= dropped_d;
        end
    end

    // Storage needs no reset: the pointers and count qualify its contents.
    always_ff @(posedge clock) begin
        if (push && !reset) begin
            mem_q[wr_ptr_q] <= in_entry;
        end
    end

    assign fb_we         = (state_q == PRESENT);
    assign fb_addr       = out_q.addr;
    assign fb_data       = out_q.colour;
    assign fifo_count    = count_q;
    assign overflow      = overflow_q;
    assign dropped_count = dropped_q;
    assign busy          = (count_q != '0) || fb_we;

endmodule

// File: tb/tb_vga_pixel_sink.sv
module tb_vga_pixel_sink;

    logic        clock = 1'b0;
    logic        reset;
    logic [7:0]  vga_x;
    logic [6:0]  vga_y;
    logic [17:0] vga_colour;
    logic        vga_write;
    logic [14:0] fb_addr;
    logic [17:0] fb_data;
    logic        fb_we;
    logic        fb_ready;
    logic [3:0]  fifo_count;
    logic        overflow;
    logic [7:0]  dropped_count;
    logic        busy;

    int total = 0;
    int bad   = 0;

    vga_pixel_sink dut (
        .clock         (clock),
        .reset         (reset),
        .vga_x         (vga_x),
        .vga_y         (vga_y),
        .vga_colour    (vga_colour),
        .vga_write     (vga_write),
        .fb_addr       (fb_addr),
        .fb_data       (fb_data),
        .fb_we         (fb_we),
        .fb_ready      (fb_ready),
        .fifo_count    (fifo_count),
        .overflow      (overflow),
        .dropped_count (dropped_count),
        .busy          (busy)
    );

    always #5 clock = ~clock;

    // Reference model: a bounded queue of pending pixels plus one
    // "currently offered" slot, updated from the behavioural rules.
    logic [32:0] m_q[$];
    logic        m_pres = 1'b0;
    logic [32:0] m_out  = '0;
    logic        m_ovf  = 1'b0;
    int          m_drop = 0;
    logic [32:0] m_log[$];
    logic [32:0] d_log[$];
    logic        last_xfer;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: apply inputs, advance DUT and model, compare at negedge.
    task automatic cyc(input logic rst, input logic w, input int x, input int y,
                       input logic [17:0] c, input logic rdy);
        logic        pre_we;
        logic [14:0] pre_a;
        logic [17:0] pre_d;
        logic        pop, inr, push;
        reset      = rst;
        vga_write  = w;
        vga_x      = 8'(x);
        vga_y      = 7'(y);
        vga_colour = c;
        fb_ready   = rdy;
        #1;
        pre_we = (fb_we === 1'b1);
        pre_a  = fb_addr;
        pre_d  = fb_data;
        last_xfer = pre_we && rdy && !rst;
        if (last_xfer) d_log.push_back({fb_addr, fb_data});
        @(posedge clock);
        if (rst) begin
            m_q.delete();
            m_pres = 1'b0;
            m_out  = '0;
            m_ovf  = 1'b0;
            m_drop = 0;
        end else begin
            pop  = (m_q.size() > 0) && (!m_pres || rdy);
            inr  = w && (x < 160) && (y < 120);
            push = inr && ((m_q.size() < 8) || pop);
            if (m_pres && rdy) m_log.push_back(m_out);
            if (pop) begin
                m_out  = m_q.pop_front();
                m_pres = 1'b1;
            end else if (rdy) begin
                m_pres = 1'b0;
            end
            if (push) m_q.push_back({15'(y * 160 + x), c});
            if (inr && !push) begin
                m_ovf = 1'b1;
                if (m_drop < 255) m_drop++;
            end
        end
        @(negedge clock);
        chk("fb_we", 64'(fb_we), 64'(m_pres));
        chk("fb_addr", 64'(fb_addr), 64'(m_out[32:18]));
        chk("fb_data", 64'(fb_data), 64'(m_out[17:0]));
        chk("fifo_count", 64'(fifo_count), 64'(m_q.size()));
        chk("overflow", 64'(overflow), 64'(m_ovf));
        chk("dropped_count", 64'(dropped_count), 64'(m_drop));
        chk("busy", 64'(busy), 64'((m_q.size() != 0) || m_pres));
        if (pre_we && !rdy && !rst) begin
            chk("hold_we", 64'(fb_we), 64'(1));
            chk("hold_addr", 64'(fb_addr), 64'(pre_a));
            chk("hold_data", 64'(fb_data), 64'(pre_d));
        end
    endtask

    task automatic idle(input int n, input logic rdy);
        for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 0, 0, 18'h0, rdy);
    endtask

    initial begin
        int base;
        int nx;
        reset = 1'b1; vga_write = 1'b0; vga_x = '0; vga_y = '0;
        vga_colour = '0; fb_ready = 1'b0;

        // Reset state
        cyc(1'b1, 1'b0, 0, 0, 18'h0, 1'b0);
        chk("rst_we", 64'(fb_we), 64'(0));
        chk("rst_count", 64'(fifo_count), 64'(0));
        chk("rst_busy", 64'(busy), 64'(0));

        // Single pixel, latency 2, one write at 490
        cyc(1'b0, 1'b1, 10, 3, 18'h3F000, 1'b1);
        chk("lat_n0_we", 64'(fb_we), 64'(0));
        cyc(1'b0, 1'b0, 0, 0, 18'h0, 1'b1);
        chk("lat_n1_we", 64'(fb_we), 64'(1));
        chk("lat_addr", 64'(fb_addr), 64'(490));
        chk("lat_data", 64'(fb_data), 64'(18'h3F000));
        cyc(1'b0, 1'b0, 0, 0, 18'h0, 1'b1);
        chk("lat_n2_we", 64'(fb_we), 64'(0));
        chk("lat_busy", 64'(busy), 64'(0));

        // Corners and clipped pixels
        base = d_log.size();
        cyc(1'b0, 1'b1, 0, 0, 18'h00001, 1'b1);
        cyc(1'b0, 1'b1, 159, 119, 18'h00002, 1'b1);
        cyc(1'b0, 1'b1, 160, 0, 18'h00003, 1'b1);
        cyc(1'b0, 1'b1, 0, 120, 18'h00004, 1'b1);
        idle(4, 1'b1);
        chk("corner_n", 64'(d_log.size() - base), 64'(2));
        chk("corner_a0", 64'(d_log[base][32:18]), 64'(0));
        chk("corner_a1", 64'(d_log[base+1][32:18]), 64'(19199));
        chk("corner_drop", 64'(dropped_count), 64'(0));
        chk("corner_ovf", 64'(overflow), 64'(0));

        // Fill with fb_ready low: 12 strobes, 3 dropped
        for (int i = 0; i < 12; i++) cyc(1'b0, 1'b1, i, 5, 18'(100 + i), 1'b0);
        chk("fill_count", 64'(fifo_count), 64'(8));
        chk("fill_addr", 64'(fb_addr), 64'(5 * 160));
        chk("fill_drop", 64'(dropped_count), 64'(3));
        chk("fill_ovf", 64'(overflow), 64'(1));
        base = d_log.size();
        for (int i = 0; i < 9; i++) begin
            cyc(1'b0, 1'b0, 0, 0, 18'h0, 1'b1);
            chk("drain_xfer", 64'(last_xfer), 64'(1));
        end
        cyc(1'b0, 1'b0, 0, 0, 18'h0, 1'b1);
        chk("drain_done", 64'(fb_we), 64'(0));
        for (int i = 0; i < 9; i++)
            chk("drain_order", 64'(d_log[base+i]), 64'({15'(5 * 160 + i), 18'(100 + i)}));

        // 5-pixel burst with fb_ready toggling
        base = d_log.size();
        for (int i = 0; i < 5; i++) cyc(1'b0, 1'b1, 20 + i, 7, 18'(200 + i), ~i[0]);
        for (int i = 0; i < 12; i++) cyc(1'b0, 1'b0, 0, 0, 18'h0, ~i[0]);
        chk("toggle_n", 64'(d_log.size() - base), 64'(5));
        for (int i = 0; i < 5; i++)
            chk("toggle_order", 64'(d_log[base+i]), 64'({15'(7 * 160 + 20 + i), 18'(200 + i)}));

        // Saturation of dropped_count
        cyc(1'b1, 1'b0, 0, 0, 18'h0, 1'b0);
        for (int i = 0; i < 300; i++) cyc(1'b0, 1'b1, i % 160, 9, 18'(i), 1'b0);
        chk("sat_drop", 64'(dropped_count), 64'(255));
        chk("sat_ovf", 64'(overflow), 64'(1));

        // Reset with data buffered and a write pending
        cyc(1'b1, 1'b0, 0, 0, 18'h0, 1'b0);
        for (int i = 0; i < 5; i++) cyc(1'b0, 1'b1, 30 + i, 11, 18'(300 + i), 1'b0);
        chk("pre_rst_we", 64'(fb_we), 64'(1));
        cyc(1'b1, 1'b0, 0, 0, 18'h0, 1'b0);
        chk("mid_rst_we", 64'(fb_we), 64'(0));
        chk("mid_rst_count", 64'(fifo_count), 64'(0));
        chk("mid_rst_ovf", 64'(overflow), 64'(0));
        chk("mid_rst_drop", 64'(dropped_count), 64'(0));
        base = d_log.size();
        idle(6, 1'b1);
        chk("mid_rst_quiet", 64'(d_log.size() - base), 64'(0));

        // Randomized traffic against the model
        for (int i = 0; i < 1500; i++) begin
            nx = (i < 750) ? 3 : 1;
            cyc(($urandom_range(0, 299) == 0),
                ($urandom_range(0, 3) != 0),
                $urandom_range(0, 175), $urandom_range(0, 127),
                18'($urandom),
                ($urandom_range(0, nx) != 0));
        end
        idle(12, 1'b1);

        // Full write history must match the model exactly
        chk("log_len", 64'(d_log.size()), 64'(m_log.size()));
        for (int i = 0; i < d_log.size() && i < m_log.size(); i++)
            chk("log_entry", 64'(d_log[i]), 64'(m_log[i]));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/vga_pixel_sink.md
Name: vga_pixel_sink

Overview:
Receiving end of the pixel-write interface driven by the game datapath (x, y, colour, write strobe). The block accepts one pixel per cycle, clips it to the 160x120 screen, buffers it in a small FIFO and drains it into a framebuffer memory port. The framebuffer port uses a valid/ready handshake. The block decouples the single-cycle write bursts of the drawing engines from a framebuffer port that may stall.

Parameters:
DEPTH_LOG2, 3, log2 of the FIFO storage depth (8 entries), excluding the output register.
SCREEN_W, 160, pixels per row; x at or above this value is clipped.
SCREEN_H, 120, rows; y at or above this value is clipped.

Ports:
clock  input  1  system clock, rising edge
reset  input  1  synchronous, active-high
vga_x  input  8  pixel column
vga_y  input  7  pixel row
vga_colour  input  18  pixel colour (6/6/6 RGB)
vga_write  input  1  pixel strobe; one pixel per cycle while high
fb_addr  output  15  framebuffer word address = y*SCREEN_W + x
fb_data  output  18  colour for fb_addr
fb_we  output  1  valid: framebuffer write pending
fb_ready  input  1  framebuffer accepts the write this cycle
fifo_count  output  DEPTH_LOG2+1  entries held in FIFO storage, excluding the output register
overflow  output  1  sticky: at least one in-range pixel was dropped because the FIFO was full
dropped_count  output  8  number of dropped in-range pixels, saturates at 255
busy  output  1  fifo_count != 0 or fb_we

Behaviour:
- Reset: synchronous, active-high. Forces fb_we=0, fb_addr=0, fb_data=0, fifo_count=0, overflow=0, dropped_count=0, busy=0. FIFO pointers are cleared.
- Reset mid-operation: all buffered pixels and any pending write are discarded. No fb_we is asserted in the cycle after reset.
- Clip: a pixel with vga_write=1 and (vga_x >= SCREEN_W or vga_y >= SCREEN_H) is silently discarded. It does not count as a drop and does not change the FIFO.
- Address: computed at push time as y*160+x = (y<<7)+(y<<5)+x, 15-bit result. The maximum is 19199, so the result never wraps. The FIFO stores {addr, colour}, 33 bits per entry.
- Push condition: vga_write=1, pixel in range, and (fifo_count < 2^DEPTH_LOG2 or a pop occurs in the same cycle).
- Drop: an in-range pixel with vga_write=1 that fails the push condition sets overflow, which stays set until reset. It also increments dropped_count, which saturates at 255 and does not wrap.
- Output stage states:
  - IDLE: fb_we=0.
  - PRESENT: fb_we=1, and fb_addr/fb_data are stable.
- IDLE to PRESENT: when the FIFO is non-empty, pop the head into the output register at the next edge.
- PRESENT with fb_ready=1: the transfer completes this cycle. If the FIFO is non-empty, pop the next entry at the same edge and stay in PRESENT (back-to-back, one write per cycle). Otherwise go to IDLE.
- PRESENT with fb_ready=0: hold fb_addr/fb_data/fb_we unchanged, with no pop.
- Pop condition: FIFO non-empty and (state=IDLE or fb_ready=1).
- Latency: with an empty FIFO and IDLE state, a pixel sampled at edge N is written to storage at N. It is loaded into the output register at N+1, so fb_we=1 in the cycle after edge N+1. Minimum latency is 2 cycles.
- Throughput: 1 pixel/cycle sustained while fb_ready is held high.
- Full capacity: 2^DEPTH_LOG2 entries plus the 1 output register.
- Simultaneous push and pop: fifo_count is unchanged. When fifo_count is at maximum, a same-cycle pop admits the push.
- Ordering: fb writes occur in exactly the accepted input order. No reordering or merging, including repeated writes to the same address.
- fb_addr/fb_data while IDLE: they retain the last presented value. Only fb_we qualifies them.

Test Plan:
- After reset, single pixel x=10, y=3, colour=18'h3F000 with fb_ready=1 -> fb_we=1 exactly one cycle, starting 2 cycles after the strobe, with fb_addr=490, fb_data=18'h3F000; busy then returns to 0.
- Corner pixels (0,0), (159,119), then clipped pixels (160,0) and (0,120) -> exactly two writes, at addr 0 and addr 19199; dropped_count=0 and overflow=0.
- fb_ready=0, 12 consecutive in-range strobes -> fifo_count=8, output register holds the first pixel, dropped_count=3, overflow=1. Raise fb_ready -> 9 writes in input order on consecutive cycles.
- fb_ready toggled 1,0,1,0 during a 5-pixel burst -> each fb_addr/fb_data is held stable while fb_ready=0. All 5 pixels are written once, in order, with no duplicates or losses.
- Hold fb_ready=0 and strobe 300 in-range pixels -> dropped_count saturates at 255 and does not wrap; overflow=1.
- Assert reset with 5 pixels buffered and fb_we=1 -> next cycle fb_we=0, fifo_count=0, overflow=0, dropped_count=0. With no new input, no further writes occur.
